ev22_reg_bank: RTL and testbench
================================

Name: ev22_reg_bank

Overview:
- Register bank at the far end of the write-back bus, i.e. the receiver of the `SEL_REG`/`DATA` pair.
- Decodes `SEL_REG`, commits `DATA` into the addressed register and pulses a one-hot write strobe.
- Serves two registered read ports (with write forwarding) to the ALU/operand stage.
- Drives the working register W back to the memory stage as `W_IN`, plus the two output-port registers.

Parameters:
- DATA_W, 16, register/data width.
- SEL_W, 6, register-select width.
- NUM_SEL, 36, number of architected select codes (0..35).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- SEL_REG  in  SEL_W  write select from the memory/write-back stage.
- DATA  in  DATA_W  write data from the memory/write-back stage.
- STALL  in  1  when high: no write, read outputs hold.
- SEL_A  in  SEL_W  read port A select.
- SEL_B  in  SEL_W  read port B select.
- RD_A  out  DATA_W  read port A data, registered.
- RD_B  out  DATA_W  read port B data, registered.
- W_IN  out  DATA_W  working register r34, to the memory stage.
- PORT_OUT0  out  DATA_W  r30 contents.
- PORT_OUT1  out  DATA_W  r31 contents.
- WR_STB  out  NUM_SEL  one-hot write strobe, registered; bit n is high for one cycle after a write to rn.

Behaviour:
- Reset (async, active-high):
  - All registers clear to 0.
  - RD_A, RD_B, W_IN, PORT_OUT0, PORT_OUT1 and WR_STB are 0 immediately.
  - Reset asserted mid-write cancels that write; no strobe is emitted.
- Select map:
  - 0..27: general registers.
  - 28, 29: reserved; writes ignored, reads return 0.
  - 30, 31: output ports 0 and 1.
  - 32, 33: auxiliary registers.
  - 34: W.
  - 35: null, no write.
  - 36..63: illegal; treated as null, reads return 0.
- Write:
  - On a rising clk with STALL=0 and SEL_REG in a writable code, the register takes DATA.
  - The write is visible on W_IN / PORT_OUTx in the next cycle.
  - WR_STB[SEL_REG] is 1 in the cycle after the write and 0 otherwise.
  - WR_STB stays all-zero for null, reserved, illegal or stalled cycles.
- Read:
  - RD_A/RD_B register the selected contents each clk when STALL=0, giving 1-cycle latency.
  - Forwarding: if SEL_A (or SEL_B) equals SEL_REG and a write is taking effect on that same edge, RD_A (or RD_B) captures the new DATA, not the old value.
  - Both ports may select the same register; both return the same value.
- STALL=1:
  - Registers, RD_A and RD_B hold.
  - WR_STB goes to 0 on the next edge.
  - W_IN and PORT_OUTx continue to reflect the held registers.
- Back-to-back writes to the same register: last write wins; WR_STB bit stays high for consecutive cycles.
- No arithmetic: data passes through unmodified at full DATA_W; there is no width conversion.

Decomposition:
- Shared package ev22_pkg holds:
  - DATA_W and SEL_W.
  - Select-code constants: SEL_PORT0=30, SEL_PORT1=31, SEL_AUX0=32, SEL_AUX1=33, SEL_W_REG=34, SEL_NULL=35.
  - Function sel_writable(sel): returns 1 for 0..27 and 30..34.
- One natural sub-module, ev22_reg_read_port: a registered mux with forwarding compare. It is instantiated twice, for ports A and B.

Test Plan:
- Reset then idle, SEL_REG=35 for 4 cycles -> all outputs 0, WR_STB stays 0.
- SEL_REG=34, DATA=16'hBEEF, one cycle -> next cycle W_IN=16'hBEEF and WR_STB[34]=1; the following cycle WR_STB=0.
- SEL_REG=5, DATA=16'h1234 with SEL_A=5 on the same edge -> RD_A=16'h1234 one cycle later (forwarded); SEL_B=5 next cycle -> RD_B=16'h1234.
- SEL_REG=30, DATA=16'h00FF, then SEL_REG=28, DATA=16'hAAAA, then SEL_REG=40, DATA=16'h5555:
  - PORT_OUT0=16'h00FF.
  - Reading 28 and 40 returns 0.
  - WR_STB is all-zero after the second and third writes.
- Write r7=16'h0001, then STALL=1 while SEL_REG=7, DATA=16'hFFFF for 3 cycles -> r7 remains 16'h0001, RD_A/RD_B frozen, WR_STB=0.
- Assert rst asynchronously (off-edge) while SEL_REG=31, DATA=16'h7777 -> PORT_OUT1 and WR_STB go to 0 immediately, with no strobe after rst deasserts.

Source files
------------

// File: rtl/ev22_pkg.sv
// Shared widths, select-code map and the writability rule for the ev22 register bank.
package ev22_pkg;

  localparam int DATA_W  = 16;
  localparam int SEL_W   = 6;
  localparam int NUM_SEL = 36;

  localparam logic [SEL_W-1:0] SEL_GP_LAST = SEL_W'(27);
  localparam logic [SEL_W-1:0] SEL_PORT0   = SEL_W'(30);
  localparam logic [SEL_W-1:0] SEL_PORT1   = SEL_W'(31);
  localparam logic [SEL_W-1:0] SEL_AUX0    = SEL_W'(32);
  localparam logic [SEL_W-1:0] SEL_AUX1    = SEL_W'(33);
  localparam logic [SEL_W-1:0] SEL_W_REG   = SEL_W'(34);
  localparam logic [SEL_W-1:0] SEL_NULL    = SEL_W'(35);

  // General registers plus ports, aux and W hold state; reserved, null and
  // illegal codes never do.
  function automatic logic sel_writable(input logic [SEL_W-1:0] sel);
    return (sel <= SEL_GP_LAST) || ((sel >= SEL_PORT0) && (sel <= SEL_W_REG));
  endfunction

endpackage

// File: rtl/ev22_reg_bank_if.sv
// Write-back bus, read ports and register taps between the pipeline and the register bank.
interface ev22_reg_bank_if;
  import ev22_pkg::*;

  logic [SEL_W-1:0]   SEL_REG;
  logic [DATA_W-1:0]  DATA;
  logic               STALL;
  logic [SEL_W-1:0]   SEL_A;
  logic [SEL_W-1:0]   SEL_B;
  logic [DATA_W-1:0]  RD_A;
  logic [DATA_W-1:0]  RD_B;
  logic [DATA_W-1:0]  W_IN;
  logic [DATA_W-1:0]  PORT_OUT0;
  logic [DATA_W-1:0]  PORT_OUT1;
  logic [NUM_SEL-1:0] WR_STB;

  modport master (
    output SEL_REG, DATA, STALL, SEL_A, SEL_B,
    input  RD_A, RD_B, W_IN, PORT_OUT0, PORT_OUT1, WR_STB
  );

  modport slave (
    input  SEL_REG, DATA, STALL, SEL_A, SEL_B,
    output RD_A, RD_B, W_IN, PORT_OUT0, PORT_OUT1, WR_STB
  );

endinterface

// File: rtl/ev22_reg_read_port.sv
// One registered read port: select mux over the bank with same-edge write forwarding.
module ev22_reg_read_port
  import ev22_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] regs [NUM_SEL],
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_p1
);

  logic [DATA_W-1:0] rd_mux_p0;
  logic [DATA_W-1:0] rd_d_p0;

  // Stage p0: pick the addressed register (0 for non-storing codes), then let a
  // write landing on the same edge override the stale contents.
  always_comb begin
    rd_mux_p0 = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if ((sel == SEL_W'(i)) && sel_writable(SEL_W'(i))) rd_mux_p0 = regs[i];
    end
    rd_d_p0 = (wr_en && (sel == wr_sel)) ? wr_data : rd_mux_p0;
  end

  // Stage p1: registered read data, frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_p1 <= '0;
    else if (!stall) rd_p1 <= rd_d_p0;
  end

endmodule

// File: rtl/ev22_reg_bank.sv
// Register bank at the end of the write-back bus: decoded writes, one-hot write
// strobe, two forwarded read ports and direct taps of W and the output ports.
module ev22_reg_bank
  import ev22_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ev22_reg_bank_if.slave bus
);

  logic [DATA_W-1:0]  regs [NUM_SEL];
  logic               wr_en_p0;
  logic [NUM_SEL-1:0] stb_p0;
  logic [NUM_SEL-1:0] stb_p1;

  assign wr_en_p0 = !bus.STALL && sel_writable(bus.SEL_REG);

  // Stage p0: one-hot decode of the write select; all-zero when no write happens.
  always_comb begin
    stb_p0 = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      stb_p0[i] = wr_en_p0 && (bus.SEL_REG == SEL_W'(i));
    end
  end

  // Register storage: the decoded strobe enables exactly one register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEL; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SEL; i++) begin
        if (stb_p0[i]) regs[i] <= bus.DATA;
      end
    end
  end

  // Stage p1: write strobe reported one cycle after the write commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stb_p1 <= '0;
    else     stb_p1 <= stb_p0;
  end

  ev22_reg_read_port u_port_a (
    .clk     (clk),
    .rst     (rst),
    .stall   (bus.STALL),
    .sel     (bus.SEL_A),
    .regs    (regs),
    .wr_en   (wr_en_p0),
    .wr_sel  (bus.SEL_REG),
    .wr_data (bus.DATA),
    .rd_p1   (bus.RD_A)
  );

  ev22_reg_read_port u_port_b (
    .clk     (clk),
    .rst     (rst),
    .stall   (bus.STALL),
    .sel     (bus.SEL_B),
    .regs    (regs),
    .wr_en   (wr_en_p0),
    .wr_sel  (bus.SEL_REG),
    .wr_data (bus.DATA),
    .rd_p1   (bus.RD_B)
  );

  assign bus.WR_STB    = stb_p1;
  assign bus.W_IN      = regs[SEL_W_REG];
  assign bus.PORT_OUT0 = regs[SEL_PORT0];
  assign bus.PORT_OUT1 = regs[SEL_PORT1];

endmodule

// File: tb/tb_ev22_reg_bank.sv
// Bench for ev22_reg_bank: directed vector table, async-reset sequence, and
// randomized traffic against a select-map reference model.
module tb_ev22_reg_bank;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  ev22_reg_bank_if bus ();

  ev22_reg_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  sel_reg;
    logic [15:0] data;
    logic        stall;
    logic [5:0]  sel_a;
    logic [5:0]  sel_b;
    logic [15:0] rd_a;
    logic [15:0] rd_b;
    logic [15:0] w_in;
    logic [15:0] p0;
    logic [15:0] p1;
    logic [35:0] stb;
  } vec_t;

  vec_t tbl [18];

  // Reference model: architected storage indexed by select code.
  logic [15:0] mem [64];
  logic [15:0] m_rd_a;
  logic [15:0] m_rd_b;
  logic [63:0] m_stb;

  function automatic bit writable(input int s);
    return (s >= 0 && s <= 27) || (s >= 30 && s <= 34);
  endfunction

  function automatic logic [35:0] bit36(input int n);
    logic [35:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input int sr, input logic [15:0] d, input logic st,
                              input int sa, input int sb,
                              input logic [15:0] ra, input logic [15:0] rb,
                              input logic [15:0] w, input logic [15:0] p0,
                              input logic [15:0] p1, input logic [35:0] stb);
    vec_t v;
    v.sel_reg = 6'(sr); v.data = d; v.stall = st; v.sel_a = 6'(sa); v.sel_b = 6'(sb);
    v.rd_a = ra; v.rd_b = rb; v.w_in = w; v.p0 = p0; v.p1 = p1; v.stb = stb;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem[i] = '0;
    m_rd_a = '0;
    m_rd_b = '0;
    m_stb  = '0;
  endtask

  task automatic model_edge();
    int sr;
    int sa;
    int sb;
    sr = int'(bus.SEL_REG);
    sa = int'(bus.SEL_A);
    sb = int'(bus.SEL_B);
    if (!bus.STALL) begin
      if (writable(sr)) mem[sr] = bus.DATA;
      m_rd_a = writable(sa) ? mem[sa] : 16'h0;
      m_rd_b = writable(sb) ? mem[sb] : 16'h0;
      m_stb  = writable(sr) ? (64'd1 << sr) : 64'd0;
    end else begin
      m_stb = '0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ra, input logic [15:0] rb,
                         input logic [15:0] w, input logic [15:0] p0,
                         input logic [15:0] p1, input logic [63:0] stb);
    chk({tag, ".RD_A"},      64'(bus.RD_A),      64'(ra));
    chk({tag, ".RD_B"},      64'(bus.RD_B),      64'(rb));
    chk({tag, ".W_IN"},      64'(bus.W_IN),      64'(w));
    chk({tag, ".PORT_OUT0"}, 64'(bus.PORT_OUT0), 64'(p0));
    chk({tag, ".PORT_OUT1"}, 64'(bus.PORT_OUT1), 64'(p1));
    chk({tag, ".WR_STB"},    64'(bus.WR_STB),    stb);
  endtask

  task automatic drive(input logic [5:0] sr, input logic [15:0] d, input logic st,
                       input logic [5:0] sa, input logic [5:0] sb);
    bus.SEL_REG = sr;
    bus.DATA    = d;
    bus.STALL   = st;
    bus.SEL_A   = sa;
    bus.SEL_B   = sb;
  endtask

  task automatic step(input logic [5:0] sr, input logic [15:0] d, input logic st,
                      input logic [5:0] sa, input logic [5:0] sb);
    drive(sr, d, st, sa, sb);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    model_reset();

    tbl[0]  = mk(35, 16'h0000, 0,  0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, '0);
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = tbl[0];
    tbl[4]  = mk(34, 16'hBEEF, 0, 34,  0, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, bit36(34));
    tbl[5]  = mk( 5, 16'h1234, 0,  5, 34, 16'h1234, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000, bit36(5));
    tbl[6]  = mk(35, 16'h0000, 0,  0,  5, 16'h0000, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000, '0);
    tbl[7]  = mk(30, 16'h00FF, 0, 30,  5, 16'h00FF, 16'h1234, 16'hBEEF, 16'h00FF, 16'h0000, bit36(30));
    tbl[8]  = mk(28, 16'hAAAA, 0, 28, 30, 16'h0000, 16'h00FF, 16'hBEEF, 16'h00FF, 16'h0000, '0);
    tbl[9]  = mk(40, 16'h5555, 0, 40, 28, 16'h0000, 16'h0000, 16'hBEEF, 16'h00FF, 16'h0000, '0);
    tbl[10] = mk( 7, 16'h0001, 0,  7,  7, 16'h0001, 16'h0001, 16'hBEEF, 16'h00FF, 16'h0000, bit36(7));
    tbl[11] = mk( 7, 16'hFFFF, 1, 34, 30, 16'h0001, 16'h0001, 16'hBEEF, 16'h00FF, 16'h0000, '0);
    tbl[12] = tbl[11];
    tbl[13] = tbl[11];
    tbl[14] = mk(35, 16'h0000, 0,  7, 34, 16'h0001, 16'hBEEF, 16'hBEEF, 16'h00FF, 16'h0000, '0);
    tbl[15] = mk(31, 16'h7777, 0, 31,  5, 16'h7777, 16'h1234, 16'hBEEF, 16'h00FF, 16'h7777, bit36(31));
    tbl[16] = mk(31, 16'h8888, 0, 31, 31, 16'h8888, 16'h8888, 16'hBEEF, 16'h00FF, 16'h8888, bit36(31));
    tbl[17] = mk(35, 16'h0000, 0, 31,  5, 16'h8888, 16'h1234, 16'hBEEF, 16'h00FF, 16'h8888, '0);

    // Power-on reset held across two edges.
    rst = 1'b1;
    drive(6'd35, 16'h0, 1'b0, 6'd0, 6'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].sel_reg, tbl[i].data, tbl[i].stall, tbl[i].sel_a, tbl[i].sel_b);
      chk_all($sformatf("vec%0d", i), tbl[i].rd_a, tbl[i].rd_b, tbl[i].w_in,
              tbl[i].p0, tbl[i].p1, 64'(tbl[i].stb));
    end

    // Async reset off-edge while a write to r31 is pending.
    drive(6'd31, 16'h7777, 1'b0, 6'd31, 6'd34);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 64'h0);
    @(posedge clk);
    #1;
    chk("rst_hold.PORT_OUT1", 64'(bus.PORT_OUT1), 64'h0);
    chk("rst_hold.WR_STB",    64'(bus.WR_STB),    64'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(6'd35, 16'h0, 1'b0, 6'd31, 6'd34);
    chk_all("post_rst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 64'h0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      logic [5:0]  sr;
      logic [5:0]  sa;
      logic [5:0]  sb;
      logic [15:0] d;
      logic        st;
      sr = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(36, 63)) : 6'($urandom_range(0, 35));
      d  = 16'($urandom);
      st = ($urandom_range(0, 4) == 0);
      sa = ($urandom_range(0, 2) == 0) ? sr : 6'($urandom_range(0, 63));
      sb = ($urandom_range(0, 2) == 0) ? sr : 6'($urandom_range(0, 63));
      step(sr, d, st, sa, sb);
      chk_all($sformatf("rnd%0d", c), m_rd_a, m_rd_b, mem[34], mem[30], mem[31], m_stb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
